// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT controller with a
// single shared request/ack memory port and registered bus outputs.
module multicycle_cpu #(
    parameter int                ADDR_W   = 32,   // 16..32
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                NREG     = 32    // power of two, 2..32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              Jump,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [ADDR_W-1:0] LOW28 = ADDR_W'(32'h0FFF_FFFF);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q, target_q, mem_addr_q;
    logic [31:0]        ir_q, mdr_q, alu_q, a_q, b_q, mem_wdata_q;
    logic               mem_req_q, mem_we_q, jump_q, halted_q;
    logic [31:0]        regs_q [NREG];

    logic [5:0]         opcode, funct;
    logic [RIDX_W-1:0]  rs_idx, rt_idx, rd_idx, wb_idx;
    logic [31:0]        imm_sext, alu_d, wb_data;
    logic               is_legal;
    logic [ADDR_W-1:0]  branch_off, jump_tgt, eff_addr;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: RIDX_W];
    assign rt_idx   = ir_q[16 +: RIDX_W];
    assign rd_idx   = ir_q[11 +: RIDX_W];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    assign is_legal = (opcode == OP_RTYPE) ? (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT})
                                           : (opcode inside {OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});

    // PC here is already the incremented value, as MIPS branch/jump semantics expect.
    assign branch_off = ADDR_W'({imm_sext[29:0], 2'b00});
    assign jump_tgt   = (pc_q & ~LOW28) | ADDR_W'({ir_q[25:0], 2'b00});
    assign eff_addr   = {alu_d[ADDR_W-1:2], 2'b00};

    assign wb_idx  = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    assign wb_data = (opcode == OP_LW) ? mdr_q : alu_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_d = a_q + imm_sext;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_SUB:   alu_d = a_q - b_q;
                F_AND:   alu_d = a_q & b_q;
                F_OR:    alu_d = a_q | b_q;
                F_SLT:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                default: alu_d = a_q + b_q;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            target_q    <= '0;
            ir_q        <= '0;
            mdr_q       <= '0;
            alu_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            jump_q      <= 1'b0;
            halted_q    <= 1'b0;
            // NOTE: the register file is reset explicitly; it is small flops, not a RAM macro.
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            jump_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (!mem_req_q) begin
                        // First cycle after reset: raise the fetch request.
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ack) begin
                        ir_q      <= mem_rdata;
                        pc_q      <= pc_q + ADDR_W'(4);
                        mem_req_q <= 1'b0;
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    a_q      <= regs_q[rs_idx];
                    b_q      <= regs_q[rt_idx];
                    target_q <= pc_q + branch_off;
                    if (!is_legal) begin
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else if (opcode == OP_J) begin
                        pc_q       <= jump_tgt;
                        jump_q     <= 1'b1;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= jump_tgt;
                        state_q    <= FETCH;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    alu_q <= alu_d;
                    case (opcode)
                        OP_BEQ: begin
                            if (a_q == b_q) pc_q <= target_q;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= (a_q == b_q) ? target_q : pc_q;
                            state_q    <= FETCH;
                        end
                        OP_LW, OP_SW: begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= (opcode == OP_SW);
                            mem_addr_q  <= eff_addr;
                            mem_wdata_q <= b_q;
                            state_q     <= MEM;
                        end
                        default: state_q <= WB;
                    endcase
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_we_q <= 1'b0;
                        if (opcode == OP_SW) begin
                            mem_addr_q <= pc_q;
                            state_q    <= FETCH;
                        end else begin
                            mdr_q     <= mem_rdata;
                            mem_req_q <= 1'b0;
                            state_q   <= WB;
                        end
                    end
                end
                WB: begin
                    if (wb_idx != '0) regs_q[wb_idx] <= wb_data;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_q;
                    state_q    <= FETCH;
                end
                HALT: state_q <= HALT;
                default: begin
                    halted_q <= 1'b1;
                    state_q  <= HALT;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign Jump      = jump_q;
    assign halted    = halted_q;
    assign pc_out    = pc_q;

endmodule
